// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the registered ALU (alu_seq).
// Holds DP opcodes, the sequencer state encoding and NZCV bit positions.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC,
        DONE
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n, start (load operands), a, b, c (accumuland), last, result.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic             run;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] acc;

    // a shifts left and b shifts right, so bit i of b meets A<<i on step i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run  <= 1'b0;
            cnt  <= '0;
            a_sh <= '0;
            b_sh <= '0;
            c_q  <= '0;
            acc  <= '0;
        end else if (start) begin
            run  <= 1'b1;
            cnt  <= CW'(WIDTH - 1);
            a_sh <= a;
            b_sh <= b;
            c_q  <= c;
            acc  <= '0;
        end else if (run) begin
            if (b_sh[0]) begin
                acc <= acc + a_sh;
            end
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
            cnt  <= cnt - CW'(1);
            if (cnt == '0) begin
                run <= 1'b0;
            end
        end
    end

    assign last = run && (cnt == '0);

    // ACC step: the accumuland is added while the top FSM sits in ACC.
    assign result = acc + c_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ARM data-processing ALU with iterative MUL/MLA and NZCV.
// Ports: CLK, RESETn, Start/Busy/Done handshake, ALUControl, S, Src_A/B/C,
// Shifter_C in; ALUResult, Write, ALUFlags out (all registered).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [4:0]       ALUControl,
    input  logic             S,
    input  logic [WIDTH-1:0] Src_A,
    input  logic [WIDTH-1:0] Src_B,
    input  logic [WIDTH-1:0] Src_C,
    input  logic             Shifter_C,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Write,
    output logic             Busy,
    output logic             Done,
    output logic [3:0]       ALUFlags
);

    state_t           state;
    logic             s_q;
    logic             is_mul;
    logic             accept;
    logic             mul_start;
    logic             mul_last;
    logic [WIDTH-1:0] mul_res;

    logic [3:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             arith;
    logic [WIDTH-1:0] lres;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_c;
    logic [3:0]       flags_c;
    logic             wr_c;

    assign is_mul    = MUL_EN && ALUControl[4];
    assign accept    = Start && (state == IDLE || state == DONE);
    assign mul_start = accept && is_mul;

    // Without a multiplier, mul-class opcodes fall through as MOV.
    assign op   = ALUControl[4] ? OP_MOV : ALUControl[3:0];
    assign wr_c = (op[3:2] != 2'b10);

    always_comb begin
        x     = Src_A;
        y     = Src_B;
        cin   = 1'b0;
        arith = 1'b0;
        lres  = '0;
        unique case (op)
            OP_SUB, OP_CMP: begin
                y     = ~Src_B;
                cin   = 1'b1;
                arith = 1'b1;
            end
            OP_RSB: begin
                x     = Src_B;
                y     = ~Src_A;
                cin   = 1'b1;
                arith = 1'b1;
            end
            OP_SBC: begin
                y     = ~Src_B;
                cin   = ALUFlags[FLAG_C];
                arith = 1'b1;
            end
            OP_RSC: begin
                x     = Src_B;
                y     = ~Src_A;
                cin   = ALUFlags[FLAG_C];
                arith = 1'b1;
            end
            OP_ADC: begin
                cin   = ALUFlags[FLAG_C];
                arith = 1'b1;
            end
            OP_ADD, OP_CMN: arith = 1'b1;
            OP_AND, OP_TST: lres = Src_A & Src_B;
            OP_EOR, OP_TEQ: lres = Src_A ^ Src_B;
            OP_ORR:         lres = Src_A | Src_B;
            OP_MOV:         lres = Src_B;
            OP_BIC:         lres = Src_A & ~Src_B;
            OP_MVN:         lres = ~Src_B;
            default:        lres = '0;
        endcase
        sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
        res_c = arith ? sum[WIDTH-1:0] : lres;
        flags_c[FLAG_N] = res_c[WIDTH-1];
        flags_c[FLAG_Z] = (res_c == '0);
        flags_c[FLAG_C] = arith ? sum[WIDTH] : Shifter_C;
        flags_c[FLAG_V] = arith
            ? ((x[WIDTH-1] == y[WIDTH-1]) && (res_c[WIDTH-1] != x[WIDTH-1]))
            : ALUFlags[FLAG_V];
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(
                .WIDTH(WIDTH)
            ) u_mul (
                .clk   (CLK),
                .rst_n (RESETn),
                .start (mul_start),
                .a     (Src_A),
                .b     (Src_B),
                .c     (ALUControl[0] ? Src_C : {WIDTH{1'b0}}),
                .last  (mul_last),
                .result(mul_res)
            );
        end else begin : g_nomul
            assign mul_last = 1'b0;
            assign mul_res  = '0;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= IDLE;
            s_q       <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Write     <= 1'b0;
            ALUResult <= '0;
            ALUFlags  <= '0;
        end else begin
            Done  <= 1'b0;
            Write <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (accept && is_mul) begin
                        state <= MUL;
                        Busy  <= 1'b1;
                        s_q   <= S;
                    end else if (accept) begin
                        state     <= DONE;
                        Done      <= 1'b1;
                        Write     <= wr_c;
                        ALUResult <= res_c;
                        if (S) begin
                            ALUFlags <= flags_c;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    if (mul_last) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    state     <= DONE;
                    Busy      <= 1'b0;
                    Done      <= 1'b1;
                    Write     <= 1'b1;
                    ALUResult <= mul_res;
                    if (s_q) begin
                        ALUFlags[FLAG_N] <= mul_res[WIDTH-1];
                        ALUFlags[FLAG_Z] <= (mul_res == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (full build and MUL_EN=0 build).
// Drives inputs 1 time unit after the rising edge and samples there as well.
module tb_alu_seq;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        Start;
    logic [4:0]  ALUControl;
    logic        S;
    logic [31:0] Src_A;
    logic [31:0] Src_B;
    logic [31:0] Src_C;
    logic        Shifter_C;
    logic [31:0] ALUResult;
    logic        Write;
    logic        Busy;
    logic        Done;
    logic [3:0]  ALUFlags;

    logic        n_start;
    logic [4:0]  n_ctl;
    logic        n_s;
    logic [31:0] n_a;
    logic [31:0] n_b;
    logic [31:0] n_c;
    logic        n_shc;
    logic [31:0] n_res;
    logic        n_write;
    logic        n_busy;
    logic        n_done;
    logic [3:0]  n_flags;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    alu_seq #(
        .WIDTH (32),
        .MUL_EN(1'b1)
    ) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .Start     (Start),
        .ALUControl(ALUControl),
        .S         (S),
        .Src_A     (Src_A),
        .Src_B     (Src_B),
        .Src_C     (Src_C),
        .Shifter_C (Shifter_C),
        .ALUResult (ALUResult),
        .Write     (Write),
        .Busy      (Busy),
        .Done      (Done),
        .ALUFlags  (ALUFlags)
    );

    alu_seq #(
        .WIDTH (32),
        .MUL_EN(1'b0)
    ) dut_nomul (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .Start     (n_start),
        .ALUControl(n_ctl),
        .S         (n_s),
        .Src_A     (n_a),
        .Src_B     (n_b),
        .Src_C     (n_c),
        .Shifter_C (n_shc),
        .ALUResult (n_res),
        .Write     (n_write),
        .Busy      (n_busy),
        .Done      (n_done),
        .ALUFlags  (n_flags)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [4:0] ctl, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
        ALUControl = ctl;
        S          = s;
        Src_A      = a;
        Src_B      = b;
        Start      = 1'b1;
    endtask

    // One-cycle issue: Start is seen at the next edge (E0), then dropped.
    task automatic issue(input logic [4:0] ctl, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
        drive(ctl, s, a, b);
        step();
        Start = 1'b0;
    endtask

    int k;
    int busy_n;

    initial begin
        RESETn     = 1'b0;
        Start      = 1'b0;
        ALUControl = '0;
        S          = 1'b0;
        Src_A      = '0;
        Src_B      = '0;
        Src_C      = '0;
        Shifter_C  = 1'b0;
        n_start    = 1'b0;
        n_ctl      = '0;
        n_s        = 1'b0;
        n_a        = '0;
        n_b        = '0;
        n_c        = '0;
        n_shc      = 1'b0;

        #2;
        chk("rst_res", ALUResult, 32'h0);
        chk("rst_flags", {28'h0, ALUFlags}, 32'h0);
        chk("rst_ctl", {29'h0, Busy, Done, Write}, 32'h0);
        #18;
        RESETn = 1'b1;

        // ADD overflow into sign bit
        issue(5'h04, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_done", {31'h0, Done}, 32'h1);
        chk("add_res", ALUResult, 32'h8000_0000);
        chk("add_flags", {28'h0, ALUFlags}, 32'h9);
        chk("add_write", {31'h0, Write}, 32'h1);
        step();
        chk("add_done_drop", {31'h0, Done}, 32'h0);
        chk("idle_write", {31'h0, Write}, 32'h0);
        chk("add_hold", ALUResult, 32'h8000_0000);

        // SUB to zero: C=1 means no borrow
        issue(5'h02, 1'b1, 32'd5, 32'd5);
        chk("sub_res", ALUResult, 32'h0);
        chk("sub_flags", {28'h0, ALUFlags}, 32'h6);

        issue(5'h06, 1'b1, 32'd10, 32'd3);
        chk("sbc_c1_res", ALUResult, 32'd7);
        chk("sbc_c1_flags", {28'h0, ALUFlags}, 32'h2);

        issue(5'h0A, 1'b1, 32'd3, 32'd5);
        chk("cmp_res", ALUResult, 32'hFFFF_FFFE);
        chk("cmp_flags", {28'h0, ALUFlags}, 32'h8);
        chk("cmp_write", {31'h0, Write}, 32'h0);
        chk("cmp_done", {31'h0, Done}, 32'h1);

        // C=0 now, so SBC subtracts one extra; S=0 keeps flags
        issue(5'h06, 1'b0, 32'd10, 32'd3);
        chk("sbc_c0_res", ALUResult, 32'd6);
        chk("sbc_c0_flags", {28'h0, ALUFlags}, 32'h8);

        // Back-to-back: MOV issued in the DONE cycle of ADD
        drive(5'h04, 1'b0, 32'h10, 32'h20);
        step();
        drive(5'h0D, 1'b0, 32'h0, 32'hA5);
        chk("b2b_done1", {31'h0, Done}, 32'h1);
        chk("b2b_res1", ALUResult, 32'h30);
        step();
        Start = 1'b0;
        chk("b2b_done2", {31'h0, Done}, 32'h1);
        chk("b2b_res2", ALUResult, 32'hA5);
        step();
        chk("b2b_done3", {31'h0, Done}, 32'h0);

        // Set C=1 V=1 ahead of the multiply
        issue(5'h04, 1'b1, 32'h8000_0000, 32'h8000_0001);
        chk("cv_res", ALUResult, 32'h1);
        chk("cv_flags", {28'h0, ALUFlags}, 32'h3);

        // MLA with a Start pulsed while Busy
        Src_C = 32'h1;
        issue(5'h11, 1'b1, 32'h0000_FFFF, 32'h0001_0001);
        k      = 1;
        busy_n = 0;
        while (!Done && k < 60) begin
            if (Busy) busy_n++;
            if (k == 9) drive(5'h04, 1'b1, 32'h1, 32'h1);
            if (k == 10) Start = 1'b0;
            step();
            k++;
        end
        chk("mla_latency", k, 34);
        chk("mla_busy_cycles", busy_n, 33);
        chk("mla_res", ALUResult, 32'h0);
        chk("mla_flags", {28'h0, ALUFlags}, 32'h7);
        chk("mla_write", {31'h0, Write}, 32'h1);
        step();
        chk("mla_done_drop", {31'h0, Done}, 32'h0);

        // Reset mid-multiply
        issue(5'h0D, 1'b0, 32'h0, 32'h55);
        chk("mov_res", ALUResult, 32'h55);
        issue(5'h10, 1'b1, 32'd3, 32'd5);
        for (int i = 1; i < 10; i++) step();
        chk("mul_busy", {31'h0, Busy}, 32'h1);
        RESETn = 1'b0;
        #1;
        chk("arst_ctl", {29'h0, Busy, Done, Write}, 32'h0);
        chk("arst_res", ALUResult, 32'h0);
        chk("arst_flags", {28'h0, ALUFlags}, 32'h0);
        drive(5'h0C, 1'b0, 32'hF0, 32'h0F);
        @(negedge CLK);
        RESETn = 1'b1;
        step();
        Start = 1'b0;
        chk("orr_done", {31'h0, Done}, 32'h1);
        chk("orr_res", ALUResult, 32'hFF);
        chk("orr_flags", {28'h0, ALUFlags}, 32'h0);

        // MUL_EN=0: mul opcode behaves as MOV
        n_ctl   = 5'h10;
        n_s     = 1'b1;
        n_a     = 32'h99;
        n_b     = 32'h1234;
        n_shc   = 1'b1;
        n_start = 1'b1;
        step();
        n_start = 1'b0;
        chk("nomul_done", {31'h0, n_done}, 32'h1);
        chk("nomul_busy", {31'h0, n_busy}, 32'h0);
        chk("nomul_res", n_res, 32'h1234);
        chk("nomul_flags", {28'h0, n_flags}, 32'h2);
        chk("nomul_write", {31'h0, n_write}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
